// File: rtl/imem_fetch.sv
// rtl/imem_fetch.sv - instruction memory with one-cycle synchronous fetch, response hold and programming port
module imem_fetch #(
    parameter int          DEPTH     = 64,
    parameter              INIT_FILE = "",
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_fault,
    input  logic        prog_en,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_wdata,
    output logic        prog_err
);

    localparam int IW = $clog2(DEPTH);

    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] mem [DEPTH];

    logic          accept;
    logic [IW-1:0] fetch_idx;
    logic          fetch_misaligned;
    logic          fetch_oor;
    logic [1:0]    fetch_fault;
    logic [31:0]   fetch_word;

    logic [IW-1:0] prog_idx;
    logic          prog_oor;
    logic          prog_write;
    logic          unused_prog_bits;

    // Default image is all NOPs.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 32'h0000_0013;
        end
    end

    assign req_ready = !prog_en && (state == EMPTY || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == FULL);

    assign fetch_idx        = req_addr[IW+1:2];
    assign fetch_misaligned = (req_addr[1:0] != 2'b00);
    assign fetch_oor        = (req_addr[31:IW+2] != '0);

    always_comb begin
        fetch_fault = FAULT_OK;
        if (fetch_misaligned) begin
            fetch_fault = FAULT_ALIGN;
        end else if (fetch_oor) begin
            fetch_fault = FAULT_RANGE;
        end
    end

    assign fetch_word = (fetch_fault == FAULT_OK) ? mem[fetch_idx] : NOP_WORD;

    assign prog_idx         = prog_addr[IW+1:2];
    assign prog_oor         = (prog_addr[31:IW+2] != '0);
    assign prog_write       = prog_en && prog_we && !prog_oor;
    assign unused_prog_bits = ^prog_addr[1:0];

    // Memory has no reset; a write coinciding with reset assertion is dropped.
    always_ff @(posedge clk) begin
        if (!reset && prog_write) begin
            mem[prog_idx] <= prog_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            rsp_data  <= 32'h0;
            rsp_fault <= FAULT_OK;
            prog_err  <= 1'b0;
        end else begin
            prog_err <= prog_en && prog_we && prog_oor;
            case (state)
                EMPTY: begin
                    if (accept) begin
                        rsp_data  <= fetch_word;
                        rsp_fault <= fetch_fault;
                        state     <= FULL;
                    end
                end
                FULL: begin
                    // Back-to-back accept replaces the word and stays FULL.
                    if (accept) begin
                        rsp_data  <= fetch_word;
                        rsp_fault <= fetch_fault;
                    end else if (rsp_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch.sv
// tb/tb_imem_fetch.sv - self-checking bench for imem_fetch
module tb_imem_fetch;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] W3    = 32'h0080_0313;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_fault;
    logic        prog_en;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_wdata;
    logic        prog_err;

    imem_fetch #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_fault  (rsp_fault),
        .prog_en    (prog_en),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .prog_err   (prog_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [31:0] mem_model [DEPTH];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  fault;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [1:0] ref_fault(input logic [31:0] a);
        if (a % 4 != 0) return 2'b01;
        if (a / 4 >= DEPTH) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_data(input logic [31:0] a);
        if (ref_fault(a) != 2'b00) return NOP;
        return mem_model[a / 4];
    endfunction

    // Entered and left just after a falling edge.
    task automatic prog_write(input logic [31:0] a, input logic [31:0] d);
        prog_en = 1'b1; prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        @(negedge clk);
        prog_we = 1'b0; prog_en = 1'b0;
        if (a / 4 < DEPTH) mem_model[a / 4] = d;
        chk("prog_err_after_write", {31'b0, prog_err}, {31'b0, (a / 4 >= DEPTH)});
    endtask

    task automatic fetch_one(input logic [31:0] a, output logic [31:0] d, output logic [1:0] f);
        req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
        #1 chk("fetch_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("fetch_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        d = rsp_data;
        f = rsp_fault;
    endtask

    logic [31:0] d;
    logic [1:0]  f;

    function automatic logic [31:0] pick_addr();
        case ($urandom % 5)
            0, 1, 2: return {24'b0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
            3:       return {24'b0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        mv;
        logic [31:0] md;
        logic [1:0]  mf;
        logic        mperr;
        logic        exp_ready;

        for (int i = 0; i < DEPTH; i++) mem_model[i] = NOP;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;

        @(negedge clk);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'h0);
        chk("reset_rsp_fault", {30'b0, rsp_fault}, 32'd0);
        chk("reset_prog_err", {31'b0, prog_err}, 32'd0);
        reset = 1'b0;
        #1 chk("post_reset_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);

        // Back-to-back default-image fetches, one response per cycle.
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = 32'(4 * i); rsp_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("b2b_valid_%0d", i), {31'b0, rsp_valid}, 32'd1);
            chk($sformatf("b2b_data_%0d", i), rsp_data, NOP);
            chk($sformatf("b2b_fault_%0d", i), {30'b0, rsp_fault}, 32'd0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_drain", {31'b0, rsp_valid}, 32'd0);

        prog_write(32'hC, W3);
        prog_write(32'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("prog_err_one_cycle", {31'b0, prog_err}, 32'd0);

        vecs[0] = '{32'h0000_0000, NOP, 2'b00};
        vecs[1] = '{32'h0000_000C, W3,  2'b00};
        vecs[2] = '{32'h0000_0006, NOP, 2'b01};
        vecs[3] = '{32'h0000_0100, NOP, 2'b10};
        vecs[4] = '{32'h0000_0102, NOP, 2'b01};
        vecs[5] = '{32'h0000_00FC, NOP, 2'b00};
        vecs[6] = '{32'h8000_0000, NOP, 2'b10};
        vecs[7] = '{32'h0000_0003, NOP, 2'b01};
        for (int i = 0; i < 8; i++) begin
            fetch_one(vecs[i].addr, d, f);
            chk($sformatf("vec%0d_data", i), d, vecs[i].data);
            chk($sformatf("vec%0d_fault", i), {30'b0, f}, {30'b0, vecs[i].fault});
        end
        @(negedge clk);

        // Stall: response held while rsp_ready=0, next fetch accepted on release.
        req_valid = 1'b1; req_addr = 32'hC; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0; req_addr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall_req_ready_%0d", k), {31'b0, req_ready}, 32'd0);
            chk($sformatf("stall_valid_%0d", k), {31'b0, rsp_valid}, 32'd1);
            chk($sformatf("stall_data_%0d", k), rsp_data, W3);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1 chk("stall_release_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("stall_next_valid", {31'b0, rsp_valid}, 32'd1);
        chk("stall_next_data", rsp_data, NOP);
        @(negedge clk);

        // prog_en raised while FULL: pending response completes, no accepts.
        req_valid = 1'b1; req_addr = 32'hC; rsp_ready = 1'b0;
        @(negedge clk);
        req_addr = 32'h0; prog_en = 1'b1;
        #1 chk("progfull_req_ready", {31'b0, req_ready}, 32'd0);
        chk("progfull_valid", {31'b0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk("progfull_hold_data", rsp_data, W3);
        rsp_ready = 1'b1;
        #1 chk("progfull_ready_blocked", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("progfull_completed", {31'b0, rsp_valid}, 32'd0);
        chk("progfull_still_blocked", {31'b0, req_ready}, 32'd0);
        prog_en = 1'b0;
        #1 chk("progfull_unblocked", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-FULL.
        req_valid = 1'b1; req_addr = 32'hC; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("areset_pre_valid", {31'b0, rsp_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("areset_valid", {31'b0, rsp_valid}, 32'd0);
        chk("areset_data", rsp_data, 32'h0);
        chk("areset_fault", {30'b0, rsp_fault}, 32'd0);
        chk("areset_prog_err", {31'b0, prog_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("areset_req_ready", {31'b0, req_ready}, 32'd1);
        fetch_one(32'hC, d, f);
        chk("areset_mem_survives", d, W3);
        @(negedge clk);
        @(negedge clk);

        // Randomised traffic against the reference model.
        mv = 1'b0; md = '0; mf = '0; mperr = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            chk("rnd_rsp_valid", {31'b0, rsp_valid}, {31'b0, mv});
            if (mv) begin
                chk("rnd_rsp_data", rsp_data, md);
                chk("rnd_rsp_fault", {30'b0, rsp_fault}, {30'b0, mf});
            end
            chk("rnd_prog_err", {31'b0, prog_err}, {31'b0, mperr});

            prog_en    = ($urandom % 6 == 0);
            prog_we    = $urandom % 2;
            prog_addr  = pick_addr();
            prog_wdata = $urandom;
            req_valid  = ($urandom % 4 != 0);
            req_addr   = pick_addr();
            rsp_ready  = ($urandom % 4 != 0);
            #1;
            exp_ready = !prog_en && (!mv || rsp_ready);
            chk("rnd_req_ready", {31'b0, req_ready}, {31'b0, exp_ready});

            mperr = prog_en && prog_we && (prog_addr / 4 >= DEPTH);
            if (prog_en && prog_we && (prog_addr / 4 < DEPTH)) mem_model[prog_addr / 4] = prog_wdata;
            if (req_valid && exp_ready) begin
                mv = 1'b1;
                md = ref_data(req_addr);
                mf = ref_fault(req_addr);
            end else if (mv && rsp_ready) begin
                mv = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
